// File: rtl/internal_framebuffer_stream_loader_pkg.sv
// Shared definitions for the internal framebuffer load path: FSM state
// encoding, default-derived width constants and bytes-per-pixel.
package internal_framebuffer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVE   = 2'd1,
        DRAIN     = 2'd2,
        WAIT_DONE = 2'd3
    } load_state_t;

    localparam int unsigned NUMBER_OF_PIXELS_PER_BEAT    = 2;
    localparam int unsigned NUMBER_OF_SUB_PIXELS         = 4;
    localparam int unsigned SUB_PIXEL_WIDTH              = 8;
    localparam int unsigned FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18;

    localparam int unsigned PIXEL_WIDTH     = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH;
    localparam int unsigned STREAM_WIDTH    = NUMBER_OF_PIXELS_PER_BEAT * PIXEL_WIDTH;
    localparam int unsigned MEM_MASK_WIDTH  = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS;
    localparam int unsigned MEM_ADDR_WIDTH  = FRAMEBUFFER_SIZE_IN_PIXEL_LG - $clog2(NUMBER_OF_PIXELS_PER_BEAT);
    localparam int unsigned BYTES_PER_PIXEL = PIXEL_WIDTH / 8;

endpackage

// File: rtl/internal_framebuffer_stream_loader_if.sv
// AXI-Stream beat channel from the DMA read engine into the loader.
// master: stream source (DMA), slave: the loader.
interface internal_framebuffer_stream_loader_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned STRB_WIDTH = 8
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [STRB_WIDTH-1:0] s_axis_tstrb;

    modport master (
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tstrb,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tstrb,
        output s_axis_tready
    );
endinterface

// File: rtl/internal_framebuffer_write_stage.sv
// Registered RAM write port: presents one accepted stream beat to the
// framebuffer RAM exactly one cycle after its handshake.
module internal_framebuffer_write_stage #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MASK_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 17
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_index,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [MASK_WIDTH-1:0] wr_mask,
    output logic [DATA_WIDTH-1:0] writeDataPort,
    output logic                  writeEnablePort,
    output logic [ADDR_WIDTH-1:0] writeAddrPort,
    output logic [MASK_WIDTH-1:0] writeMaskPort
);

    // Strobe follows each handshake; address/data/mask hold between writes.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            writeEnablePort <= 1'b0;
            writeAddrPort   <= '0;
            writeDataPort   <= '0;
            writeMaskPort   <= '0;
        end else begin
            writeEnablePort <= wr_valid;
            if (wr_valid) begin
                writeAddrPort <= wr_index;
                writeDataPort <= wr_data;
                writeMaskPort <= wr_mask;
            end
        end
    end

endmodule

// File: rtl/internal_framebuffer_stream_loader.sv
// Loads a block of external memory into the internal framebuffer RAM:
// requests a DMA read, then writes each returned stream beat to RAM,
// masked by tstrb and the per-channel colour mask.
// Optional: INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN adds a sticky
// errStatus output (bit0 early tlast, bit1 surplus beats drained).
module internal_framebuffer_stream_loader
    import internal_framebuffer_pkg::*;
#(
    parameter int unsigned NUMBER_OF_PIXELS_PER_BEAT    = 2,
    parameter int unsigned NUMBER_OF_SUB_PIXELS         = 4,
    parameter int unsigned SUB_PIXEL_WIDTH              = 8,
    parameter int unsigned FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
    parameter int unsigned FB_SIZE_IN_PIXEL_LG          = 20,
    parameter int unsigned ADDR_WIDTH                   = 32,
    localparam int unsigned PIX_W    = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int unsigned STREAM_W = NUMBER_OF_PIXELS_PER_BEAT * PIX_W,
    localparam int unsigned MASK_W   = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS,
    localparam int unsigned LG_PPB   = $clog2(NUMBER_OF_PIXELS_PER_BEAT),
    localparam int unsigned MADDR_W  = FRAMEBUFFER_SIZE_IN_PIXEL_LG - LG_PPB,
    localparam int unsigned BPP      = PIX_W / 8
) (
    input  logic                            aclk,
    input  logic                            resetn,
    input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,
    input  logic                            apply,
    output logic                            applied,
    input  logic                            cmdLoad,
    input  logic [FB_SIZE_IN_PIXEL_LG-1:0]  cmdSize,
    input  logic [ADDR_WIDTH-1:0]           cmdAddr,
    output logic [STREAM_W-1:0]             writeDataPort,
    output logic                            writeEnablePort,
    output logic [MADDR_W-1:0]              writeAddrPort,
    output logic [MASK_W-1:0]               writeMaskPort,
    internal_framebuffer_stream_loader_if.slave s_axis,
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
    output logic [1:0]                      errStatus,
`endif
    output logic                            m_tstart,
    output logic [ADDR_WIDTH-1:0]           m_taddr,
    output logic [ADDR_WIDTH-1:0]           m_tbytes,
    input  logic                            m_tdone
);

    load_state_t        state;
    logic [MADDR_W-1:0] size_beats;
    logic [MADDR_W-1:0] index;
    logic [MADDR_W-1:0] index_next;
    logic [MADDR_W-1:0] cmd_beats;
    logic               hs;
    logic               wr_valid;
    logic [MASK_W-1:0]  wr_mask;

    assign s_axis.s_axis_tready = (state == RECEIVE) || (state == DRAIN);
    assign hs         = s_axis.s_axis_tvalid && s_axis.s_axis_tready;
    assign wr_valid   = hs && (state == RECEIVE);
    assign index_next = index + MADDR_W'(1);
    assign cmd_beats  = MADDR_W'(cmdSize >> LG_PPB);
    assign wr_mask    = s_axis.s_axis_tstrb & {NUMBER_OF_PIXELS_PER_BEAT{confMask}};

    // Command FSM: DMA request, beat counting, drain and completion wait.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            size_beats <= '0;
            index      <= '0;
            applied    <= 1'b1;
            m_tstart   <= 1'b0;
            m_taddr    <= '0;
            m_tbytes   <= '0;
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
            errStatus  <= '0;
`endif
        end else begin
            if (m_tstart && m_tdone)
                m_tstart <= 1'b0;
            case (state)
                IDLE: begin
                    if (apply && cmdLoad && !m_tstart) begin
                        size_beats <= cmd_beats;
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
                        errStatus  <= '0;
`endif
                        if (cmd_beats != '0) begin
                            m_tstart <= 1'b1;
                            m_taddr  <= cmdAddr;
                            m_tbytes <= ADDR_WIDTH'(cmdSize) * ADDR_WIDTH'(BPP);
                            applied  <= 1'b0;
                            index    <= '0;
                            state    <= RECEIVE;
                        end
                    end
                end
                RECEIVE: begin
                    if (hs) begin
                        index <= index_next;
                        if (s_axis.s_axis_tlast) begin
                            state <= WAIT_DONE;
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
                            if (index_next != size_beats)
                                errStatus[0] <= 1'b1;
`endif
                        end else if (index_next == size_beats) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (hs) begin
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
                        errStatus[1] <= 1'b1;
`endif
                        if (s_axis.s_axis_tlast)
                            state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!m_tstart) begin
                        state   <= IDLE;
                        applied <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    internal_framebuffer_write_stage #(
        .DATA_WIDTH (STREAM_W),
        .MASK_WIDTH (MASK_W),
        .ADDR_WIDTH (MADDR_W)
    ) u_write_stage (
        .aclk            (aclk),
        .resetn          (resetn),
        .wr_valid        (wr_valid),
        .wr_index        (index),
        .wr_data         (s_axis.s_axis_tdata),
        .wr_mask         (wr_mask),
        .writeDataPort   (writeDataPort),
        .writeEnablePort (writeEnablePort),
        .writeAddrPort   (writeAddrPort),
        .writeMaskPort   (writeMaskPort)
    );

endmodule

// File: tb/tb_internal_framebuffer_stream_loader.sv
// Directed, table-driven bench for internal_framebuffer_stream_loader.
module tb_internal_framebuffer_stream_loader;

    logic        aclk = 1'b0;
    logic        resetn;
    logic [3:0]  confMask;
    logic        apply;
    logic        applied;
    logic        cmdLoad;
    logic [19:0] cmdSize;
    logic [31:0] cmdAddr;
    logic [63:0] writeDataPort;
    logic        writeEnablePort;
    logic [16:0] writeAddrPort;
    logic [7:0]  writeMaskPort;
    logic        m_tstart;
    logic [31:0] m_taddr;
    logic [31:0] m_tbytes;
    logic        m_tdone;
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
    logic [1:0]  errStatus;
`endif

    internal_framebuffer_stream_loader_if #(.DATA_WIDTH(64), .STRB_WIDTH(8)) axis_if ();

    internal_framebuffer_stream_loader dut (
        .aclk            (aclk),
        .resetn          (resetn),
        .confMask        (confMask),
        .apply           (apply),
        .applied         (applied),
        .cmdLoad         (cmdLoad),
        .cmdSize         (cmdSize),
        .cmdAddr         (cmdAddr),
        .writeDataPort   (writeDataPort),
        .writeEnablePort (writeEnablePort),
        .writeAddrPort   (writeAddrPort),
        .writeMaskPort   (writeMaskPort),
        .s_axis          (axis_if),
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
        .errStatus       (errStatus),
`endif
        .m_tstart        (m_tstart),
        .m_taddr         (m_taddr),
        .m_tbytes        (m_tbytes),
        .m_tdone         (m_tdone)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        valid;
        logic        last;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [3:0]  conf;
        logic        exp_rdy;
        logic        exp_we;
        int          exp_addr;
        logic [7:0]  exp_mask;
    } vec_t;

    vec_t vecs [0:22];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic valid, logic last, logic [63:0] data, logic [7:0] strb,
                                logic [3:0] conf, logic rdy, logic we, int addr, logic [7:0] mask);
        vec_t v;
        v.valid = valid; v.last = last; v.data = data; v.strb = strb; v.conf = conf;
        v.exp_rdy = rdy; v.exp_we = we; v.exp_addr = addr; v.exp_mask = mask;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(logic [19:0] size, logic [31:0] addr, logic load, logic exp_start);
        @(negedge aclk);
        apply = 1'b1; cmdLoad = load; cmdSize = size; cmdAddr = addr;
        @(negedge aclk);
        apply = 1'b0; cmdLoad = 1'b0;
        check("cmd_tstart", 64'(m_tstart), 64'(exp_start));
        check("cmd_applied", 64'(applied), 64'(!exp_start));
        if (exp_start) begin
            check("cmd_taddr", 64'(m_taddr), 64'(addr));
            check("cmd_tbytes", 64'(m_tbytes), 64'(size) * 64'd4);
        end
    endtask

    task automatic run_vecs(int first, int last_i);
        for (int i = first; i <= last_i; i++) begin
            confMask              = vecs[i].conf;
            axis_if.s_axis_tvalid = vecs[i].valid;
            axis_if.s_axis_tlast  = vecs[i].last;
            axis_if.s_axis_tdata  = vecs[i].data;
            axis_if.s_axis_tstrb  = vecs[i].strb;
            #1;
            check($sformatf("v%0d_tready", i), 64'(axis_if.s_axis_tready), 64'(vecs[i].exp_rdy));
            @(negedge aclk);
            check($sformatf("v%0d_we", i), 64'(writeEnablePort), 64'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_addr", i), 64'(writeAddrPort), 64'(vecs[i].exp_addr));
                check($sformatf("v%0d_data", i), writeDataPort, vecs[i].data);
                check($sformatf("v%0d_mask", i), 64'(writeMaskPort), 64'(vecs[i].exp_mask));
            end
        end
        axis_if.s_axis_tvalid = 1'b0;
        axis_if.s_axis_tlast  = 1'b0;
    endtask

    task automatic finish_dma();
        int n;
        if (m_tstart) begin
            m_tdone = 1'b1;
            @(negedge aclk);
            m_tdone = 1'b0;
        end
        n = 0;
        while (!applied && n < 10) begin
            @(negedge aclk);
            n++;
        end
        check("done_applied", 64'(applied), 64'd1);
        check("done_tstart", 64'(m_tstart), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // normal load with gaps in tvalid
        vecs[0]  = mk(1, 0, 64'h1111_0000_AAAA_0000, 8'hFF, 4'hF, 1, 1, 0, 8'hFF);
        vecs[1]  = mk(0, 0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 4'hF, 1, 0, 0, 8'h00);
        vecs[2]  = mk(0, 0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 4'hF, 1, 0, 0, 8'h00);
        vecs[3]  = mk(1, 0, 64'h2222_0000_BBBB_0001, 8'hFF, 4'hF, 1, 1, 1, 8'hFF);
        vecs[4]  = mk(1, 0, 64'h3333_0000_CCCC_0002, 8'hFF, 4'hF, 1, 1, 2, 8'hFF);
        vecs[5]  = mk(0, 0, 64'h0,                   8'hFF, 4'hF, 1, 0, 0, 8'h00);
        vecs[6]  = mk(1, 1, 64'h4444_0000_DDDD_0003, 8'hFF, 4'hF, 1, 1, 3, 8'hFF);
        vecs[7]  = mk(1, 0, 64'h5555_5555_5555_5555, 8'hFF, 4'hF, 0, 0, 0, 8'h00);
        // colour mask x tstrb
        vecs[8]  = mk(1, 0, 64'h0102_0304_0506_0708, 8'hF0, 4'h7, 1, 1, 0, 8'h70);
        vecs[9]  = mk(1, 0, 64'h1112_1314_1516_1718, 8'hFF, 4'h7, 1, 1, 1, 8'h77);
        vecs[10] = mk(1, 0, 64'h2122_2324_2526_2728, 8'h0F, 4'h7, 1, 1, 2, 8'h07);
        vecs[11] = mk(1, 1, 64'h3132_3334_3536_3738, 8'hF0, 4'h7, 1, 1, 3, 8'h70);
        vecs[12] = mk(1, 0, 64'h0,                   8'hFF, 4'h7, 0, 0, 0, 8'h00);
        // early tlast
        vecs[13] = mk(1, 0, 64'hA0A0_A0A0_A0A0_A0A0, 8'hFF, 4'hF, 1, 1, 0, 8'hFF);
        vecs[14] = mk(1, 1, 64'hA1A1_A1A1_A1A1_A1A1, 8'hFF, 4'hF, 1, 1, 1, 8'hFF);
        vecs[15] = mk(1, 0, 64'hA2A2_A2A2_A2A2_A2A2, 8'hFF, 4'hF, 0, 0, 0, 8'h00);
        // surplus beats drained
        vecs[16] = mk(1, 0, 64'hB0B0_B0B0_B0B0_B0B0, 8'hFF, 4'hF, 1, 1, 0, 8'hFF);
        vecs[17] = mk(1, 0, 64'hB1B1_B1B1_B1B1_B1B1, 8'h3C, 4'hF, 1, 1, 1, 8'h3C);
        vecs[18] = mk(1, 0, 64'hB2B2_B2B2_B2B2_B2B2, 8'hFF, 4'hF, 1, 1, 2, 8'hFF);
        vecs[19] = mk(1, 0, 64'hB3B3_B3B3_B3B3_B3B3, 8'hFF, 4'hF, 1, 1, 3, 8'hFF);
        vecs[20] = mk(1, 0, 64'hB4B4_B4B4_B4B4_B4B4, 8'hFF, 4'hF, 1, 0, 0, 8'h00);
        vecs[21] = mk(1, 1, 64'hB5B5_B5B5_B5B5_B5B5, 8'hFF, 4'hF, 1, 0, 0, 8'h00);
        vecs[22] = mk(1, 0, 64'hB6B6_B6B6_B6B6_B6B6, 8'hFF, 4'hF, 0, 0, 0, 8'h00);

        resetn = 1'b0; confMask = 4'hF; apply = 1'b0; cmdLoad = 1'b0;
        cmdSize = '0; cmdAddr = '0; m_tdone = 1'b0;
        axis_if.s_axis_tvalid = 1'b0; axis_if.s_axis_tlast = 1'b0;
        axis_if.s_axis_tdata = '0; axis_if.s_axis_tstrb = '0;
        repeat (3) @(negedge aclk);

        check("rst_applied", 64'(applied), 64'd1);
        check("rst_tstart", 64'(m_tstart), 64'd0);
        check("rst_tready", 64'(axis_if.s_axis_tready), 64'd0);
        check("rst_we", 64'(writeEnablePort), 64'd0);
        check("rst_addr", 64'(writeAddrPort), 64'd0);
        check("rst_mask", 64'(writeMaskPort), 64'd0);
        check("rst_data", writeDataPort, 64'd0);
        check("rst_taddr", 64'(m_taddr), 64'd0);
        check("rst_tbytes", 64'(m_tbytes), 64'd0);
        resetn = 1'b1;

        // apply without cmdLoad is ignored
        issue_cmd(20'd8, 32'h0000_3000, 1'b0, 1'b0);

        issue_cmd(20'd8, 32'h0000_1000, 1'b1, 1'b1);
        run_vecs(0, 7);
        finish_dma();

        issue_cmd(20'd8, 32'h0000_2000, 1'b1, 1'b1);
        run_vecs(8, 12);
        finish_dma();

        // early m_tdone, then stream ends early with tlast on beat 2
        issue_cmd(20'd8, 32'h0000_4000, 1'b1, 1'b1);
        m_tdone = 1'b1;
        @(negedge aclk);
        m_tdone = 1'b0;
        check("early_done_tstart", 64'(m_tstart), 64'd0);
        check("early_done_applied", 64'(applied), 64'd0);
        run_vecs(13, 15);
        check("early_tlast_applied", 64'(applied), 64'd1);
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
        check("err_early_tlast", 64'(errStatus), 64'd1);
`endif

        issue_cmd(20'd8, 32'h0000_5000, 1'b1, 1'b1);
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
        check("err_cleared", 64'(errStatus), 64'd0);
`endif
        run_vecs(16, 22);
`ifdef INTERNAL_FRAMEBUFFER_STREAM_LOADER_ERROR_STATUS_EN
        check("err_drain", 64'(errStatus), 64'd2);
`endif
        finish_dma();

        // one pixel rounds down to zero beats: no request
        issue_cmd(20'd1, 32'h0000_6000, 1'b1, 1'b0);
        @(negedge aclk);
        check("size1_tstart", 64'(m_tstart), 64'd0);
        check("size1_applied", 64'(applied), 64'd1);

        // asynchronous reset in the middle of RECEIVE
        issue_cmd(20'd8, 32'h0000_7000, 1'b1, 1'b1);
        axis_if.s_axis_tvalid = 1'b1;
        axis_if.s_axis_tdata  = 64'hC0C0_C0C0_C0C0_C0C0;
        axis_if.s_axis_tstrb  = 8'hFF;
        @(negedge aclk);
        check("mid_we", 64'(writeEnablePort), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("arst_tstart", 64'(m_tstart), 64'd0);
        check("arst_tready", 64'(axis_if.s_axis_tready), 64'd0);
        check("arst_applied", 64'(applied), 64'd1);
        check("arst_we", 64'(writeEnablePort), 64'd0);
        axis_if.s_axis_tvalid = 1'b0;
        @(negedge aclk);
        resetn = 1'b1;
        @(negedge aclk);
        check("post_rst_tready", 64'(axis_if.s_axis_tready), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
